// File: rtl/pipeline_step_controller_pkg.sv
// Shared definitions for the pipeline step controller.
//   - 3-bit state encodings and the FSM state type
//   - index of the hard-wired zero register (never a real dependency)
//   - helper deciding whether the MEM stage needs the memory this step
package pipeline_step_controller_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DATA  = 3'd1;
    localparam logic [2:0] ST_FETCH = 3'd2;
    localparam logic [2:0] ST_ADV   = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_DATA  = ST_DATA,
        S_FETCH = ST_FETCH,
        S_ADV   = ST_ADV,
        S_ERR   = ST_ERR
    } state_e;

    localparam logic [4:0] X0_IDX = 5'd0;

    function automatic logic mem_access_pending(input logic mem_read, input logic mem_write);
        return mem_read | mem_write;
    endfunction

endpackage

// File: rtl/pipeline_step_controller_if.sv
// Memory handshake between the step controller and the unified memory port.
//   mem_req       controller -> memory  request valid
//   mem_sel_data  controller -> memory  1 = data address drives memory, 0 = PC
//   data_capture  controller -> datapath pulse: latch data read result
//   if_capture    controller -> datapath pulse: latch fetched instruction
//   mem_ready     memory -> controller  current request completes this cycle
interface pipeline_step_controller_if;
    logic mem_req;
    logic mem_sel_data;
    logic data_capture;
    logic if_capture;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_sel_data,
        output data_capture,
        output if_capture,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_sel_data,
        input  data_capture,
        input  if_capture,
        output mem_ready
    );
endinterface

// File: rtl/pipeline_step_controller_load_use_detector.sv
// Load-use detector: flags an ID-stage instruction that reads the register a
// load in EX is about to write, which MEM/WB forwarding cannot cover.
//   mem_read_i  EX instruction is a load
//   rd_i        EX destination register
//   rs1_i/rs2_i ID source registers
//   load_use_o  stall required (combinational)
module pipeline_step_controller_load_use_detector
    import pipeline_step_controller_pkg::*;
(
    input  logic       mem_read_i,
    input  logic [4:0] rd_i,
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    output logic       load_use_o
);

    // x0 is never written, so a load targeting it creates no dependency.
    assign load_use_o = mem_read_i & (rd_i != X0_IDX) & ((rd_i == rs1_i) | (rd_i == rs2_i));

endmodule

// File: rtl/pipeline_step_controller.sv
// Pipeline step controller: shares one single-ported memory between the
// MEM-stage data access and the IF fetch, then issues one advance pulse per
// step with load-use stall and taken-branch flush applied.
//   clk, rst             clock, asynchronous active-high reset
//   mif (master)         memory request/select/capture strobes, mem_ready in
//   ID_EX_*, IF_ID_*     load-use hazard operands (sampled only in S_ADV)
//   EX_MEM_MemRead/Write MEM-stage access request for the next step
//   branch_taken         EX resolved a taken branch
//   pc_write, pipe_write, id_ex_bubble, if_id_flush  advance-step enables
//   mem_error            sticky memory timeout flag
//   stall_cycles         saturating count of cycles without an advance pulse
module pipeline_step_controller
    import pipeline_step_controller_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    pipeline_step_controller_if.master mif,
    input  logic                       ID_EX_MemRead,
    input  logic [4:0]                 ID_EX_RegisterRd,
    input  logic [4:0]                 IF_ID_RegisterRs1,
    input  logic [4:0]                 IF_ID_RegisterRs2,
    input  logic                       EX_MEM_MemRead,
    input  logic                       EX_MEM_MemWrite,
    input  logic                       branch_taken,
    output logic                       pc_write,
    output logic                       pipe_write,
    output logic                       id_ex_bubble,
    output logic                       if_id_flush,
    output logic                       mem_error,
    output logic [CNT_W-1:0]           stall_cycles
);

    localparam int                WAIT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_e            state_q;
    logic [WAIT_W-1:0] wait_q;
    logic              data_rd_q;
    logic              mem_error_q;
    logic [CNT_W-1:0]  stall_q;
    logic [CNT_W-1:0]  stall_d;

    logic load_use_s;
    logic in_data_s;
    logic in_fetch_s;
    logic in_adv_s;
    logic mem_req_s;
    logic mem_sel_data_s;
    logic data_capture_s;
    logic if_capture_s;
    logic pc_write_s;
    logic pipe_write_s;
    logic id_ex_bubble_s;
    logic if_id_flush_s;
    logic adv_pulse_s;

    pipeline_step_controller_load_use_detector u_load_use (
        .mem_read_i (ID_EX_MemRead),
        .rd_i       (ID_EX_RegisterRd),
        .rs1_i      (IF_ID_RegisterRs1),
        .rs2_i      (IF_ID_RegisterRs2),
        .load_use_o (load_use_s)
    );

    // Memory strobes decode from state; a data write completes without a capture pulse.
    always_comb begin
        in_data_s      = (state_q == S_DATA);
        in_fetch_s     = (state_q == S_FETCH);
        in_adv_s       = (state_q == S_ADV);
        mem_req_s      = in_data_s | in_fetch_s;
        mem_sel_data_s = in_data_s;
        data_capture_s = in_data_s & mif.mem_ready & data_rd_q;
        if_capture_s   = in_fetch_s & mif.mem_ready;
    end

    // Advance enables exist only in S_ADV, so hazard inputs reach no output elsewhere.
    always_comb begin
        pc_write_s     = 1'b0;
        pipe_write_s   = 1'b0;
        id_ex_bubble_s = 1'b0;
        if_id_flush_s  = 1'b0;
        if (in_adv_s) begin
            pipe_write_s = 1'b1;
            if (branch_taken) begin
                // Wrong-path instructions in IF/ID and ID die; the stall is moot.
                pc_write_s     = 1'b1;
                id_ex_bubble_s = 1'b1;
                if_id_flush_s  = 1'b1;
            end else if (load_use_s) begin
                // PC holds so the same word is refetched next step.
                pc_write_s     = 1'b0;
                id_ex_bubble_s = 1'b1;
                if_id_flush_s  = 1'b0;
            end else begin
                pc_write_s     = 1'b1;
                id_ex_bubble_s = 1'b0;
                if_id_flush_s  = 1'b0;
            end
        end else begin
            pipe_write_s = 1'b0;
        end
        adv_pulse_s = in_adv_s & pc_write_s;
    end

    // Stall counter next value: counts every non-advancing cycle and sticks at all-ones.
    always_comb begin
        if (adv_pulse_s || (stall_q == {CNT_W{1'b1}})) begin
            stall_d = stall_q;
        end else begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    // Step FSM with wait counter and sticky timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wait_q      <= '0;
            data_rd_q   <= 1'b0;
            mem_error_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_ADV: begin
                    wait_q <= '0;
                    // Latch read-vs-write so S_DATA never looks at the EX/MEM inputs.
                    data_rd_q <= EX_MEM_MemRead;
                    if (mem_access_pending(EX_MEM_MemRead, EX_MEM_MemWrite)) begin
                        state_q <= S_DATA;
                    end else begin
                        state_q <= S_FETCH;
                    end
                end
                S_DATA, S_FETCH: begin
                    if (mif.mem_ready) begin
                        wait_q  <= '0;
                        state_q <= (state_q == S_DATA) ? S_FETCH : S_ADV;
                    end else if (wait_q == WAIT_LAST) begin
                        // TIMEOUT cycles waited with no ready: give up for good.
                        state_q     <= S_ERR;
                        mem_error_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                S_ERR: begin
                    state_q     <= S_ERR;
                    mem_error_q <= 1'b1;
                end
                default: begin
                    state_q     <= S_ERR;
                    mem_error_q <= 1'b1;
                end
            endcase
        end
    end

    // Performance counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign mif.mem_req      = mem_req_s;
    assign mif.mem_sel_data = mem_sel_data_s;
    assign mif.data_capture = data_capture_s;
    assign mif.if_capture   = if_capture_s;
    assign pc_write         = pc_write_s;
    assign pipe_write       = pipe_write_s;
    assign id_ex_bubble     = id_ex_bubble_s;
    assign if_id_flush      = if_id_flush_s;
    assign mem_error        = mem_error_q;
    assign stall_cycles     = stall_q;

endmodule

// File: tb/tb_pipeline_step_controller.sv
// Scoreboard bench for pipeline_step_controller (TIMEOUT=8, CNT_W=5).
// Stimulus pushes the expected advance-step enables and the stall_cycles value
// seen during that step; a monitor pops and compares whenever the DUT shows
// pipe_write or data_capture. A memory responder drives mem_ready.
module tb_pipeline_step_controller;

    localparam int TIMEOUT_TB = 8;
    localparam int CNT_W_TB   = 5;

    typedef struct packed {
        logic                pc;
        logic                bub;
        logic                fl;
        logic [CNT_W_TB-1:0] stall;
    } adv_exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                ID_EX_MemRead = 1'b0;
    logic [4:0]          ID_EX_RegisterRd = 5'd0;
    logic [4:0]          IF_ID_RegisterRs1 = 5'd0;
    logic [4:0]          IF_ID_RegisterRs2 = 5'd0;
    logic                EX_MEM_MemRead = 1'b0;
    logic                EX_MEM_MemWrite = 1'b0;
    logic                branch_taken = 1'b0;
    logic                pc_write;
    logic                pipe_write;
    logic                id_ex_bubble;
    logic                if_id_flush;
    logic                mem_error;
    logic [CNT_W_TB-1:0] stall_cycles;

    int checks = 0;
    int errors = 0;
    int lat_data = 2;
    int lat_fetch = 0;
    bit mem_hold = 1'b0;
    int rsp_cnt = 0;

    adv_exp_t adv_q[$];
    int       cap_q[$];
    adv_exp_t mon_e;
    int       mon_c;

    pipeline_step_controller_if mif();

    pipeline_step_controller #(
        .TIMEOUT (TIMEOUT_TB),
        .CNT_W   (CNT_W_TB)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .mif               (mif),
        .ID_EX_MemRead     (ID_EX_MemRead),
        .ID_EX_RegisterRd  (ID_EX_RegisterRd),
        .IF_ID_RegisterRs1 (IF_ID_RegisterRs1),
        .IF_ID_RegisterRs2 (IF_ID_RegisterRs2),
        .EX_MEM_MemRead    (EX_MEM_MemRead),
        .EX_MEM_MemWrite   (EX_MEM_MemWrite),
        .branch_taken      (branch_taken),
        .pc_write          (pc_write),
        .pipe_write        (pipe_write),
        .id_ex_bubble      (id_ex_bubble),
        .if_id_flush       (if_id_flush),
        .mem_error         (mem_error),
        .stall_cycles      (stall_cycles)
    );

    always #5 clk = ~clk;

    // Memory model: answers each request after lat_* non-ready cycles.
    initial begin
        mif.mem_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || !mif.mem_req) begin
                mif.mem_ready = 1'b0;
                rsp_cnt = 0;
            end else if (mem_hold) begin
                mif.mem_ready = 1'b0;
            end else if (rsp_cnt >= (mif.mem_sel_data ? lat_data : lat_fetch)) begin
                mif.mem_ready = 1'b1;
                rsp_cnt = 0;
            end else begin
                mif.mem_ready = 1'b0;
                rsp_cnt++;
            end
        end
    end

    // Monitor: compares every advance step and every data capture against the queues.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst && pipe_write) begin
                checks++;
                if (adv_q.size() == 0) begin
                    errors++;
                    $display("FAIL adv_unexpected: pulse pc=%0b stall=%0d, required no step", pc_write, stall_cycles);
                end else begin
                    mon_e = adv_q.pop_front();
                    if ({pc_write, id_ex_bubble, if_id_flush, stall_cycles, mif.mem_req} !==
                        {mon_e.pc, mon_e.bub, mon_e.fl, mon_e.stall, 1'b0}) begin
                        errors++;
                        $display("FAIL adv_step: got pc=%0b bub=%0b fl=%0b stall=%0d req=%0b, required pc=%0b bub=%0b fl=%0b stall=%0d req=0",
                                 pc_write, id_ex_bubble, if_id_flush, stall_cycles, mif.mem_req,
                                 mon_e.pc, mon_e.bub, mon_e.fl, mon_e.stall);
                    end
                end
            end
            if (!rst && mif.data_capture) begin
                checks++;
                if (cap_q.size() == 0) begin
                    errors++;
                    $display("FAIL cap_unexpected: data_capture at stall=%0d, required none", stall_cycles);
                end else begin
                    mon_c = cap_q.pop_front();
                    if (32'(stall_cycles) != mon_c) begin
                        errors++;
                        $display("FAIL data_capture: at stall=%0d, required at stall=%0d", stall_cycles, mon_c);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Apply one step's inputs, queue its expected ADV result, wait until that ADV is over.
    task automatic run_step(input logic br, input logic ldr, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic mr, input logic mw,
                            input logic e_pc, input logic e_bub, input logic e_fl, input int e_stall);
        adv_exp_t e;
        int n;
        branch_taken      = br;
        ID_EX_MemRead     = ldr;
        ID_EX_RegisterRd  = rd;
        IF_ID_RegisterRs1 = rs1;
        IF_ID_RegisterRs2 = rs2;
        EX_MEM_MemRead    = mr;
        EX_MEM_MemWrite   = mw;
        e.pc    = e_pc;
        e.bub   = e_bub;
        e.fl    = e_fl;
        e.stall = CNT_W_TB'(e_stall);
        adv_q.push_back(e);
        n = 0;
        while (pipe_write !== 1'b1 && n < 100) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL step_timeout: no advance step within %0d cycles, required one", n);
        end
        @(negedge clk);
        #2;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        #2;
        check("rst_mem_req", 32'(mif.mem_req), 32'd0);
        check("rst_pc_write", 32'(pc_write), 32'd0);
        check("rst_pipe_write", 32'(pipe_write), 32'd0);
        check("rst_mem_error", 32'(mem_error), 32'd0);
        check("rst_stall", 32'(stall_cycles), 32'd0);
        rst = 1'b0;

        //       br    ldr   rd     rs1    rs2    mr    mw      pc    bub   fl   stall
        run_step(1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0,   1'b1, 1'b0, 1'b0, 2);
        run_step(1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0,   1'b1, 1'b0, 1'b0, 3);
        run_step(1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 1'b0,   1'b1, 1'b0, 1'b0, 4);
        // Data read, ready on 3rd data cycle: capture at stall=6, pulse on cycle 5
        cap_q.push_back(6);
        run_step(1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0,   1'b1, 1'b0, 1'b0, 8);
        // Load-use via Rs2
        run_step(1'b0, 1'b1, 5'd5,  5'd0,  5'd5,  1'b0, 1'b0,   1'b0, 1'b1, 1'b0, 9);
        // Load to x0: no stall
        run_step(1'b0, 1'b1, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0,   1'b1, 1'b0, 1'b0, 11);
        // Branch overrides load-use
        run_step(1'b1, 1'b1, 5'd7,  5'd7,  5'd3,  1'b0, 1'b0,   1'b1, 1'b1, 1'b1, 12);
        // Branch alone; next step does a data write (no capture)
        run_step(1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b1,   1'b1, 1'b1, 1'b1, 13);
        // Load-use via Rs1 after the write step
        run_step(1'b0, 1'b1, 5'd9,  5'd9,  5'd0,  1'b0, 1'b0,   1'b0, 1'b1, 1'b0, 17);
        // Matching registers but no load
        run_step(1'b0, 1'b0, 5'd9,  5'd9,  5'd0,  1'b0, 1'b0,   1'b1, 1'b0, 1'b0, 19);
        // Load with no register match; next step waits long in S_DATA
        lat_data = 10;
        run_step(1'b0, 1'b1, 5'd31, 5'd1,  5'd2,  1'b1, 1'b0,   1'b1, 1'b0, 1'b0, 20);

        // Reset in the middle of S_DATA
        check("mid_data_req", 32'({mif.mem_req, mif.mem_sel_data}), 32'd3);
        branch_taken = 1'b0;
        ID_EX_MemRead = 1'b0;
        EX_MEM_MemRead = 1'b0;
        EX_MEM_MemWrite = 1'b0;
        mem_hold = 1'b1;
        rst = 1'b1;
        #1;
        check("async_rst_outs", 32'({mif.mem_req, mif.mem_sel_data, mif.if_capture, pc_write, pipe_write, mem_error}), 32'd0);
        check("async_rst_stall", 32'(stall_cycles), 32'd0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        check("idle_after_rst", 32'(mif.mem_req), 32'd0);

        // Timeout: mem_ready held low for the whole fetch
        for (int w = 1; w <= TIMEOUT_TB; w++) begin
            @(negedge clk);
            #2;
            if (w == 1) begin
                check("fetch_after_idle", 32'({mif.mem_req, mif.mem_sel_data}), 32'd2);
            end
        end
        check("wait8_no_error", 32'({mem_error, mif.mem_req}), 32'd1);
        check("wait8_stall", 32'(stall_cycles), 32'd8);
        @(negedge clk);
        #2;
        check("timeout_error", 32'({mem_error, mif.mem_req}), 32'd2);
        check("timeout_stall", 32'(stall_cycles), 32'd9);
        repeat (30) @(negedge clk);
        #2;
        check("error_sticky", 32'({mem_error, pc_write, pipe_write}), 32'd4);
        check("stall_saturate", 32'(stall_cycles), 32'd31);
        rst = 1'b1;
        #1;
        check("error_cleared", 32'({mem_error, stall_cycles}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        check("adv_queue_empty", 32'(adv_q.size()), 32'd0);
        check("cap_queue_empty", 32'(cap_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
